// File: rtl/load_unit.sv
// load_unit: data cache load path with req/ack, timeout and sub-word extraction.
// Optional MISALIGN_TRAP_EN: trap misaligned LH/LHU/LW on accept.
module load_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_addr,
  input  logic [2:0]       funct3,
  output logic             ld_ready,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] read_data,
  output logic             data_valid,
  output logic             stall,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(TIMEOUT) + 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    off;
  logic [2:0]    f3;
  logic          accept;
  logic          illegal;
  logic          bad;
  logic [WIDTH-1:0] ext;

  assign ld_ready = (state == IDLE) || (state == DONE);
  assign accept   = ld_valid && ld_ready;

  // funct3 encodings with no load behind them
  always_comb begin
    illegal = 1'b0;
    unique case (1'b1)
      (funct3 == 3'b011): illegal = 1'b1;
      (funct3 == 3'b110): illegal = 1'b1;
      (funct3 == 3'b111): illegal = 1'b1;
      default:            illegal = 1'b0;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign;
  // halfwords need even offsets, words need offset zero
  always_comb begin
    misalign = 1'b0;
    if (funct3[1:0] == 2'b01)
      misalign = ld_addr[0];
    else if (funct3[1:0] == 2'b10)
      misalign = (ld_addr[1:0] != 2'b00);
  end
  assign bad = illegal || misalign;
`else
  assign bad = illegal;
`endif

  // pick byte/half by the latched offset and extend per the latched funct3
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b   = mem_rdata[8*off +: 8];
    h   = mem_rdata[16*off[1] +: 16];
    ext = '0;
    case (f3)
      3'b000:  ext = {{(WIDTH-8){b[7]}}, b};
      3'b001:  ext = {{(WIDTH-16){h[15]}}, h};
      3'b010:  ext = mem_rdata;
      3'b100:  ext = {{(WIDTH-8){1'b0}}, b};
      3'b101:  ext = {{(WIDTH-16){1'b0}}, h};
      default: ext = '0;
    endcase
  end

  // control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      off        <= '0;
      f3         <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      read_data  <= '0;
      data_valid <= 1'b0;
      err        <= 1'b0;
      stall      <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            off      <= ld_addr[1:0];
            f3       <= funct3;
            mem_addr <= {ld_addr[WIDTH-1:2], 2'b00};
            cnt      <= '0;
            if (bad) begin
              state      <= DONE;
              read_data  <= '0;
              data_valid <= 1'b1;
              err        <= 1'b1;
            end else begin
              state   <= WAIT;
              mem_req <= 1'b1;
              stall   <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (mem_ack) begin
            state      <= DONE;
            read_data  <= ext;
            data_valid <= 1'b1;
            mem_req    <= 1'b0;
            stall      <= 1'b0;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state      <= DONE;
            read_data  <= '0;
            data_valid <= 1'b1;
            err        <= 1'b1;
            mem_req    <= 1'b0;
            stall      <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          stall   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed vector table plus reset and back-to-back sequences.
// Honours MISALIGN_TRAP_EN for the misaligned vectors.
module tb_load_unit;

  localparam int TIMEOUT = 64;

  logic        clk;
  logic        rst_n;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [2:0]  funct3;
  logic        ld_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] read_data;
  logic        data_valid;
  logic        stall;
  logic        err;

  int nvec;
  int nfail;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] addr;
    logic [31:0] rdata;
    int          dly;
    logic [31:0] exp;
    logic        experr;
    logic        expreq;
  } vec_t;

  vec_t vecs[13];

  load_unit #(.WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ld_valid(ld_valid),
    .ld_addr(ld_addr),
    .funct3(funct3),
    .ld_ready(ld_ready),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .read_data(read_data),
    .data_valid(data_valid),
    .stall(stall),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int  stalls;
    int  expst;
    bit  seen;
    bit  reqseen;
    bit  addrbad;
    logic [31:0] ea;
    string tag;
    tag     = $sformatf("v%0d", id);
    ea      = {v.addr[31:2], 2'b00};
    stalls  = 0;
    seen    = 0;
    reqseen = 0;
    addrbad = 0;
    if (!v.expreq)
      expst = 0;
    else if (v.dly < 0)
      expst = TIMEOUT;
    else
      expst = v.dly + 1;
    @(negedge clk);
    chk({tag, " ready"}, 32'(ld_ready), 32'd1);
    ld_valid = 1'b1;
    ld_addr  = v.addr;
    funct3   = v.f;
    @(negedge clk);
    ld_valid = 1'b0;
    for (int c = 0; c < TIMEOUT + 10; c++) begin
      if (data_valid) begin
        seen = 1;
        break;
      end
      if (mem_req) reqseen = 1;
      if (stall) begin
        stalls++;
        if (mem_addr !== ea || mem_req !== 1'b1) addrbad = 1;
      end
      mem_rdata = v.rdata;
      mem_ack   = stall && (v.dly >= 0) && (stalls - 1 == v.dly);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    chk({tag, " data_valid seen"}, 32'(seen), 32'd1);
    chk({tag, " read_data"}, read_data, v.exp);
    chk({tag, " err"}, 32'(err), 32'(v.experr));
    chk({tag, " stall cycles"}, stalls, expst);
    chk({tag, " mem_req seen"}, 32'(reqseen), 32'(v.expreq));
    chk({tag, " mem_addr/req stable"}, 32'(addrbad), 32'd0);
    chk({tag, " req low in done"}, 32'(mem_req), 32'd0);
    @(negedge clk);
    chk({tag, " dv pulse"}, 32'(data_valid), 32'd0);
    chk({tag, " err pulse"}, 32'(err), 32'd0);
    chk({tag, " rd hold"}, read_data, v.exp);
    chk({tag, " idle ready"}, 32'(ld_ready), 32'd1);
  endtask

  initial begin
    nvec      = 0;
    nfail     = 0;
    rst_n     = 1'b0;
    ld_valid  = 1'b0;
    ld_addr   = '0;
    funct3    = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;

    vecs[0]  = '{3'b010, 32'h100, 32'hDEADBEEF, 0,
                 32'hDEADBEEF, 1'b0, 1'b1};
    vecs[1]  = '{3'b000, 32'h103, 32'h80112233, 0,
                 32'hFFFFFF80, 1'b0, 1'b1};
    vecs[2]  = '{3'b100, 32'h103, 32'h80112233, 1,
                 32'h00000080, 1'b0, 1'b1};
    vecs[3]  = '{3'b101, 32'h102, 32'h80112233, 0,
                 32'h00008011, 1'b0, 1'b1};
    vecs[4]  = '{3'b001, 32'h200, 32'h0000F00F, 4,
                 32'hFFFFF00F, 1'b0, 1'b1};
    vecs[5]  = '{3'b000, 32'h101, 32'h80112233, 2,
                 32'h00000022, 1'b0, 1'b1};
    vecs[6]  = '{3'b001, 32'h100, 32'h80112233, 0,
                 32'h00002233, 1'b0, 1'b1};
    vecs[7]  = '{3'b010, 32'h300, 32'h55555555, -1,
                 32'h00000000, 1'b1, 1'b1};
    vecs[8]  = '{3'b010, 32'h304, 32'h12345678, TIMEOUT - 1,
                 32'h12345678, 1'b0, 1'b1};
    vecs[9]  = '{3'b011, 32'h100, 32'hFFFFFFFF, 0,
                 32'h00000000, 1'b1, 1'b0};
    vecs[10] = '{3'b110, 32'h108, 32'hFFFFFFFF, 0,
                 32'h00000000, 1'b1, 1'b0};
`ifdef MISALIGN_TRAP_EN
    vecs[11] = '{3'b010, 32'h101, 32'hCAFEF00D, 0,
                 32'h00000000, 1'b1, 1'b0};
    vecs[12] = '{3'b101, 32'h103, 32'h9ABC1234, 0,
                 32'h00000000, 1'b1, 1'b0};
`else
    vecs[11] = '{3'b010, 32'h101, 32'hCAFEF00D, 0,
                 32'hCAFEF00D, 1'b0, 1'b1};
    vecs[12] = '{3'b101, 32'h103, 32'h9ABC1234, 0,
                 32'h00009ABC, 1'b0, 1'b1};
`endif

    #2;
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst read_data", read_data, 32'd0);
    chk("rst data_valid", 32'(data_valid), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst ready", 32'(ld_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++)
      run_vec(vecs[i], i);

    // back-to-back: new accept while in DONE
    @(negedge clk);
    ld_valid = 1'b1;
    ld_addr  = 32'h500;
    funct3   = 3'b010;
    @(negedge clk);
    ld_valid  = 1'b0;
    mem_rdata = 32'h80112233;
    mem_ack   = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("b2b first dv", 32'(data_valid), 32'd1);
    chk("b2b first rd", read_data, 32'h80112233);
    ld_valid = 1'b1;
    ld_addr  = 32'h503;
    funct3   = 3'b100;
    @(negedge clk);
    ld_valid = 1'b0;
    chk("b2b second stall", 32'(stall), 32'd1);
    chk("b2b second dv low", 32'(data_valid), 32'd0);
    chk("b2b second addr", mem_addr, 32'h500);
    mem_rdata = 32'h80112233;
    mem_ack   = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("b2b second dv", 32'(data_valid), 32'd1);
    chk("b2b second rd", read_data, 32'h00000080);

    // async reset in WAIT, then stray acks
    @(negedge clk);
    ld_valid = 1'b1;
    ld_addr  = 32'h400;
    funct3   = 3'b010;
    @(negedge clk);
    ld_valid = 1'b0;
    @(negedge clk);
    chk("wait stall", 32'(stall), 32'd1);
    chk("wait req", 32'(mem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid rst req", 32'(mem_req), 32'd0);
    chk("mid rst stall", 32'(stall), 32'd0);
    chk("mid rst rd", read_data, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_rdata = 32'h11111111;
    mem_ack   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stray ack dv %0d", k), 32'(data_valid), 32'd0);
      chk($sformatf("stray ack stall %0d", k), 32'(stall), 32'd0);
    end
    mem_ack = 1'b0;
    chk("stray ack rd", read_data, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
